// File: rtl/rv_g_pkg.sv
// Shared core package: register widths and register-file address encoding.
package rv_g_pkg;

   localparam int unsigned DEF_XLEN = 64;
   localparam int unsigned DEF_FLEN = 32;

   // bit 5 selects the FP register file, bits 4:0 index within the file
   localparam int unsigned REG_FILE_SEL_BIT = 5;
   localparam logic        FP_FILE_SEL      = 1'b1;

   typedef logic [5:0] reg_addr_t;

endpackage

// File: rtl/rv_g_wb_arbiter_pkg.sv
// Writeback-arbiter local constants and the payload width helper.
package rv_g_wb_arbiter_pkg;
   import rv_g_pkg::*;

   localparam int unsigned DEF_NUM_SRC = 4;

   function automatic int unsigned max_len(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   localparam int unsigned DEF_MAX_LEN = max_len(DEF_XLEN, DEF_FLEN);

endpackage

// File: rtl/rv_g_wb_arbiter_if.sv
// Producer result handshakes plus the register-file write port, as seen by the arbiter.
interface rv_g_wb_arbiter_if
   import rv_g_pkg::*;
   import rv_g_wb_arbiter_pkg::*;
#(
   parameter int unsigned NUM_SRC = DEF_NUM_SRC,
   parameter int unsigned MaxLen  = DEF_MAX_LEN
);

   logic      [NUM_SRC-1:0]             src_valid;
   reg_addr_t [NUM_SRC-1:0]             src_addr;
   logic      [NUM_SRC-1:0][MaxLen-1:0] src_data;
   logic      [NUM_SRC-1:0]             src_ready;

   logic                                wr_en;
   reg_addr_t                           wr_addr;
   logic      [MaxLen-1:0]              wr_data;

   // producers and register file side
   modport master (
      output src_valid, src_addr, src_data,
      input  src_ready, wr_en, wr_addr, wr_data
   );

   // arbiter side
   modport slave (
      input  src_valid, src_addr, src_data,
      output src_ready, wr_en, wr_addr, wr_data
   );

endinterface

// File: rtl/rv_g_wb_arbiter_rr_arbiter.sv
// Generic round-robin arbiter: searches from ptr upward with wrap, ptr moves past each winner.
module rr_arbiter #(
   parameter  int unsigned N    = 4,
   localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk_i,
   input  logic            arst_ni,
   input  logic [N-1:0]    req_i,
   input  logic            adv_i,
   output logic [N-1:0]    gnt_o,
   output logic [IdxW-1:0] gnt_idx_o
);

   logic [IdxW-1:0] ptr_q, ptr_d;
   logic            found;
   int unsigned     idx;
   logic [IdxW-1:0] idx_s;

   // first requester at or after ptr, wrapping through N-1 back to 0
   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      idx       = 0;
      idx_s     = '0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = 32'(ptr_q) + k;
         if (idx >= N) idx = idx - N;
         idx_s = IdxW'(idx);
         if (!found && req_i[idx_s]) begin
            found        = 1'b1;
            gnt_o[idx_s] = 1'b1;
            gnt_idx_o    = idx_s;
         end
      end
   end

   // pointer lands just past the winner; holds when nothing is granted
   always_comb begin
      ptr_d = ptr_q;
      if (adv_i && found) begin
         ptr_d = (gnt_idx_o == IdxW'(N - 1)) ? '0 : gnt_idx_o + IdxW'(1);
      end
   end

   // pointer register
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) ptr_q <= '0;
      else          ptr_q <= ptr_d;
   end

endmodule

// File: rtl/rv_g_wb_arbiter.sv
// Writeback arbiter: one producer result per cycle into the register-file write port.
module rv_g_wb_arbiter
   import rv_g_pkg::*;
   import rv_g_wb_arbiter_pkg::*;
#(
   parameter int unsigned NUM_SRC = DEF_NUM_SRC,
   parameter int unsigned XLEN    = DEF_XLEN,
   parameter int unsigned FLEN    = DEF_FLEN
) (
   input logic                clk_i,
   input logic                arst_ni,
   rv_g_wb_arbiter_if.slave   wb
);

   localparam int unsigned MaxLen = max_len(XLEN, FLEN);
   localparam int unsigned IdxW   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   logic [NUM_SRC-1:0] gnt;
   logic [IdxW-1:0]    gnt_idx;
   logic               any_valid;
   reg_addr_t          sel_addr;
   logic [MaxLen-1:0]  sel_data;

   logic               wr_en_q,   wr_en_d;
   reg_addr_t          wr_addr_q, wr_addr_d;
   logic [MaxLen-1:0]  wr_data_q, wr_data_d;

   // the write port never stalls, so any valid source is accepted this cycle
   assign any_valid = |wb.src_valid;

   rr_arbiter #(.N(NUM_SRC)) u_rr (
      .clk_i     (clk_i),
      .arst_ni   (arst_ni),
      .req_i     (wb.src_valid),
      .adv_i     (any_valid),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx)
   );

   assign wb.src_ready = gnt;
   assign sel_addr     = wb.src_addr[gnt_idx];
   assign sel_data     = wb.src_data[gnt_idx];

   // output stage loads the winner; address/data hold on idle cycles
   always_comb begin
      wr_en_d   = any_valid;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (any_valid) begin
         wr_addr_d = sel_addr;
         wr_data_d = sel_data;
      end
   end

   // output register; an accepted but unwritten result is dropped on reset
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign wb.wr_en   = wr_en_q;
   assign wb.wr_addr = wr_addr_q;
   assign wb.wr_data = wr_data_q;

endmodule
